conv_stream_feeder: RTL

- Source end of the conv unit's pixel stream: reads D channel planes of one feature map from on-chip buffers and drives oValid/oData1..3 straight into the conv unit's iValid/iData1..3.
- Raster order, one pixel per cycle per channel, with a hold input for pausing.
- Start/done handshake toward the layer controller.
- Sits between the feature-map SRAMs and the conv unit's line buffers.

---
 rtl/conv_stream_feeder_pkg.sv | 19 +
 rtl/conv_stream_feeder_delay_line.sv | 30 +++
 rtl/conv_stream_feeder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/conv_stream_feeder_pkg.sv
// Shared definitions for the conv stream feeder: FSM encoding, pipeline latency
// and map-size helper.
package conv_stream_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } feeder_state_e;

    // Cycles from mem_rd_en to oValid: one SRAM read cycle plus the output register.
    localparam int unsigned FEED_LAT = 2;

    function automatic int unsigned calc_n(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/conv_stream_feeder_delay_line.sv
// Fixed-depth register chain for the valid/last side-band flags; every stage is
// exposed so the data register can be enabled from the first tap.
module feeder_delay_line
    import conv_stream_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = FEED_LAT
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [WIDTH-1:0]            d_i,
    output logic [DEPTH-1:0][WIDTH-1:0] taps_o
);

    logic [DEPTH-1:0][WIDTH-1:0] taps_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taps_q <= '0;
        end else begin
            taps_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/conv_stream_feeder.sv
// Streams one D-channel feature map from on-chip SRAMs to the conv unit in
// raster order, with hold-based pausing and a start/done handshake.
module conv_stream_feeder
    import conv_stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned D          = 3,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata1,
    input  logic [DATA_WIDTH-1:0] mem_rdata2,
    input  logic [DATA_WIDTH-1:0] mem_rdata3,
    output logic                  oValid,
    output logic [DATA_WIDTH-1:0] oData1,
    output logic [DATA_WIDTH-1:0] oData2,
    output logic [DATA_WIDTH-1:0] oData3,
    output logic                  oLast
);

    localparam int unsigned           N_PIX     = calc_n(IMG_W, IMG_H);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIX - 1);

    feeder_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  drain_q, drain_d;
    logic                  rd_en;
    logic                  issue_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    addr_d  = '0;
                end
            end
            STREAM: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    // Counter parks on the last address instead of wrapping.
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = FINISH;
                end else begin
                    drain_d = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issue_last = rd_en && (addr_q == LAST_ADDR);
    assign mem_rd_en  = rd_en;
    assign mem_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);

    // Bit 0 carries valid, bit 1 carries last.
    logic [FEED_LAT-1:0][1:0] flag_taps;
    logic                     unused_mid_last;

    feeder_delay_line #(
        .WIDTH(2),
        .DEPTH(FEED_LAT)
    ) u_flags (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   ({issue_last, rd_en}),
        .taps_o(flag_taps)
    );

    assign oValid          = flag_taps[FEED_LAT-1][0];
    assign oLast           = flag_taps[FEED_LAT-1][1];
    assign unused_mid_last = flag_taps[0][1];

    logic [DATA_WIDTH-1:0] rdata  [D];
    logic [DATA_WIDTH-1:0] odata_q[D];

    assign rdata[0] = mem_rdata1;
    assign rdata[1] = mem_rdata2;
    assign rdata[2] = mem_rdata3;

    // SRAM data is valid exactly when the first flag tap shows a read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < D; i++) begin
                odata_q[i] <= '0;
            end
        end else if (flag_taps[0][0]) begin
            for (int unsigned i = 0; i < D; i++) begin
                odata_q[i] <= rdata[i];
            end
        end
    end

    assign oData1 = odata_q[0];
    assign oData2 = odata_q[1];
    assign oData3 = odata_q[2];

endmodule
